// File: rtl/divider.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, result 33 cycles after start.
// Shares the run/stall handshake with the shift-add multiplier; signed mode gives floored results.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        u,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        divz
);

    localparam logic [5:0] S_DONE = 6'd33;

    logic [5:0]  s_q, s_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic        neg_q, neg_d;

    logic [31:0] r_shift;
    logic [32:0] trial;
    logic        load_neg;

    assign r_shift  = {r_q[30:0], q_q[31]};
    assign trial    = {1'b0, r_shift} - {1'b0, y};
    assign load_neg = u & x[31];

    always_comb begin
        s_d   = s_q;
        r_d   = r_q;
        q_d   = q_q;
        neg_d = neg_q;
        if (!run) begin
            s_d = 6'd0;
        end else if (s_q == 6'd0) begin
            neg_d = load_neg;
            q_d   = load_neg ? (~x + 32'd1) : x;
            r_d   = 32'd0;
            s_d   = 6'd1;
        end else if (s_q != S_DONE) begin
            // Keep the trial difference only when it did not borrow.
            if (!trial[32]) begin
                r_d = trial[31:0];
                q_d = {q_q[30:0], 1'b1};
            end else begin
                r_d = r_shift;
                q_d = {q_q[30:0], 1'b0};
            end
            s_d = s_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 6'd0;
            r_q   <= 32'd0;
            q_q   <= 32'd0;
            neg_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            r_q   <= r_d;
            q_q   <= q_d;
            neg_q <= neg_d;
        end
    end

    assign stall = run & (s_q != S_DONE);

    // Negative dividend: |x| = Q*y + R becomes x = (-Q-1)*y + (y-R) when R is nonzero.
    always_comb begin
        divz = (y == 32'd0);
        quot = q_q;
        rem  = r_q;
        if (divz) begin
            quot = 32'hFFFF_FFFF;
            rem  = r_q;
        end else if (neg_q) begin
            if (r_q == 32'd0) begin
                quot = ~q_q + 32'd1;
                rem  = 32'd0;
            end else begin
                quot = ~q_q;
                rem  = y - r_q;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases, randomized divides against an
// arithmetic floored-division model, handshake hold, reset and run-drop aborts.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst, run, u;
    logic [31:0] x, y;
    logic        stall, divz;
    logic [31:0] quot, rem;

    int vectors = 0;
    int miscompares = 0;

    divider dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .u     (u),
        .x     (x),
        .y     (y),
        .stall (stall),
        .quot  (quot),
        .rem   (rem),
        .divz  (divz)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] xa, input logic [31:0] ya, input logic ua,
                                    output logic [31:0] q, output logic [31:0] r);
        longint xs, ys, qs, rs;
        if (ya == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = (ua && xa[31]) ? (~xa + 32'd1) : xa;
            return;
        end
        xs = ua ? longint'($signed(xa)) : longint'({32'b0, xa});
        ys = longint'({32'b0, ya});
        qs = xs / ys;
        rs = xs % ys;
        if (rs < 0) begin
            rs = rs + ys;
            qs = qs - 1;
        end
        q = qs[31:0];
        r = rs[31:0];
    endfunction

    // Counts stalled cycles from the current (low-phase) point until stall drops; bounded.
    task automatic wait_stalls(output int n);
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_div(input logic [31:0] xa, input logic [31:0] ya, input logic ua);
        @(negedge clk);
        x = xa; y = ya; u = ua; run = 1'b1;
    endtask

    task automatic drop_run();
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; u = 1'b0; x = 32'd55; y = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (quot !== 32'd0 || rem !== 32'd0 || divz !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: quot=%h rem=%h divz=%b stall=%b, want 0 0 0 0", quot, rem, divz, stall);
        end
        run = 1'b1; y = 32'd0;
        @(negedge clk); #1;
        vectors++;
        if (stall !== 1'b1 || divz !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_run: stall=%b divz=%b, want 1 1", stall, divz);
        end
        run = 1'b0; rst = 1'b0; y = 32'd5;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] tx [7] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'hFFFF_FFF9,
                                32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFF9};
        logic [31:0] ty [7] = '{32'd7, 32'd2, 32'd2, 32'd2, 32'd1, 32'd0, 32'd0};
        logic        tu [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] eq [7] = '{32'd14, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h7FFF_FFFC,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] er [7] = '{32'd2, 32'd1, 32'd0, 32'd1, 32'd0, 32'h1234_5678, 32'd7};
        int n;
        for (int i = 0; i < 7; i++) begin
            start_div(tx[i], ty[i], tu[i]);
            wait_stalls(n);
            vectors++;
            if (n !== 33) begin
                miscompares++;
                $display("FAIL dir%0d_stalls: got %0d cycles, want 33", i, n);
            end
            vectors++;
            if (quot !== eq[i] || rem !== er[i] || divz !== (ty[i] == 32'd0)) begin
                miscompares++;
                $display("FAIL dir%0d_result: quot=%h rem=%h divz=%b, want %h %h %b",
                         i, quot, rem, divz, eq[i], er[i], ty[i] == 32'd0);
            end
            drop_run();
        end
    endtask

    task automatic test_random();
        logic [31:0] xa, ya, eq, er;
        logic        ua;
        int n;
        for (int i = 0; i < 40; i++) begin
            xa = $urandom;
            ua = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       ya = 32'd0;
                1, 2:    ya = $urandom_range(1, 20);
                default: ya = $urandom & 32'h7FFF_FFFF;
            endcase
            if (i % 5 == 0) xa = xa | 32'h8000_0000;
            ref_div(xa, ya, ua, eq, er);
            start_div(xa, ya, ua);
            @(negedge clk);
            x = $urandom;
            wait_stalls(n);
            n = n + 1;
            vectors++;
            if (n !== 33 || quot !== eq || rem !== er || divz !== (ya == 32'd0)) begin
                miscompares++;
                $display("FAIL rand%0d: x=%h y=%h u=%b stalls=%0d quot=%h rem=%h divz=%b, want 33 %h %h %b",
                         i, xa, ya, ua, n, quot, rem, divz, eq, er, ya == 32'd0);
            end
            drop_run();
        end
    endtask

    task automatic test_handshake();
        logic [31:0] eq, er;
        int n;
        ref_div(32'hFFFF_FF00, 32'd13, 1'b1, eq, er);
        start_div(32'hFFFF_FF00, 32'd13, 1'b1);
        wait_stalls(n);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            x = $urandom;
            #1;
            vectors++;
            if (stall !== 1'b0 || quot !== eq || rem !== er) begin
                miscompares++;
                $display("FAIL hold%0d: stall=%b quot=%h rem=%h, want 0 %h %h", k, stall, quot, rem, eq, er);
            end
        end
        drop_run();
        start_div(32'd9, 32'd3, 1'b0);
        wait_stalls(n);
        vectors++;
        if (n !== 33 || quot !== 32'd3 || rem !== 32'd0) begin
            miscompares++;
            $display("FAIL back_to_back: stalls=%0d quot=%h rem=%h, want 33 3 0", n, quot, rem);
        end
        drop_run();
    endtask

    task automatic test_reset_mid();
        int n;
        start_div(32'd1000, 32'd7, 1'b0);
        repeat (17) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b1 || quot !== 32'd0 || rem !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_clear: stall=%b quot=%h rem=%h, want 1 0 0", stall, quot, rem);
        end
        wait_stalls(n);
        vectors++;
        if (n !== 33 || quot !== 32'd142 || rem !== 32'd6) begin
            miscompares++;
            $display("FAIL rst_mid_result: stalls=%0d quot=%0d rem=%0d, want 33 142 6", n, quot, rem);
        end
        drop_run();
    endtask

    task automatic test_abort();
        int n;
        start_div(32'd5000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        x = 32'hFFFF_FFF6;
        u = 1'b1;
        @(negedge clk);
        run = 1'b1;
        wait_stalls(n);
        vectors++;
        if (n !== 33 || quot !== 32'hFFFF_FFFC || rem !== 32'd2) begin
            miscompares++;
            $display("FAIL abort_reload: stalls=%0d quot=%h rem=%h, want 33 fffffffc 2", n, quot, rem);
        end
        drop_run();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; u = 1'b0; x = 32'd0; y = 32'd1;
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_reset_mid();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative 32-bit restoring divider. It is the inverse-operation companion to the processor's shift-add multiplier and uses the same run/stall handshake, so the CPU execute stage stalls on it in the same way.
- Computes quotient and remainder of x by y. In signed mode, division is floored for a positive divisor: the remainder is always in [0, y).
- Takes one quotient bit per cycle. The result is available 33 cycles after the divider is started.

Parameters:
- None. Width is fixed at 32.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- run  input  1  held high by the CPU for the whole divide; low = idle
- u  input  1  1 = x is signed (two's complement); 0 = x is unsigned
- stall  output  1  combinational; high while a divide is in progress
- x  input  32  dividend; sampled only in the load cycle
- y  input  32  divisor; always unsigned; must be held stable while run is high
- quot  output  32  quotient
- rem  output  32  remainder
- divz  output  1  high when y == 0; valid whenever stall is low and run is high

Behaviour:
- State:
  - S: 6-bit step counter.
  - R: 32-bit partial remainder.
  - Q: 32-bit dividend/quotient shift register.
  - neg: 1-bit sign flag.
- Reset (rst=1 at a clock edge):
  - S=0, R=0, Q=0, neg=0.
  - Outputs after reset: quot=0, rem=0, divz=(y==0), stall=run&1.
  - rst has priority over run. Asserting rst mid-divide aborts the divide. The next run starts a fresh divide from S=0.
- Counter:
  - Each edge: if run=0, S<=0. If run=1 and S<33, S<=S+1. If run=1 and S=33, S holds at 33.
- Stall:
  - stall = run & (S != 33).
  - Run first sampled with S=0 gives 33 stalled cycles (S=0..32). stall falls in the cycle where S=33.
  - The CPU takes the result in that S=33 cycle and then drops run.
- Load cycle (S=0, run=1):
  - neg <= u & x[31].
  - Q <= neg ? -x : x (32-bit two's complement; x=0x80000000 gives magnitude 0x80000000).
  - R <= 0.
- Step cycles (S=1..32):
  - Form the shifted pair {R,Q}<<1, i.e. R' = {R[30:0],Q[31]}.
  - Compute the 33-bit trial d = {1'b0,R'} - {1'b0,y}.
  - If d[32]=0: R <= d[31:0] and Q <= {Q[30:0],1}.
  - Otherwise: R <= R' and Q <= {Q[30:0],0}.
- Output fixup (combinational from Q, R, neg, y):
  - y==0: divz=1, quot=0xFFFFFFFF, rem=R. The raw result is R=|x|. The sign fixup is skipped.
  - neg=0: quot=Q, rem=R.
  - neg=1 and R=0: quot=-Q, rem=0.
  - neg=1 and R!=0: quot=-Q-1 (i.e. ~Q), rem=y-R.
- Outputs are only meaningful when run=1 and S=33. They stay stable while run is held at S=33.
- Changing x mid-divide has no effect. Changing y or u mid-divide gives undefined results (not checked).
- Dropping run mid-divide returns S to 0. The partial state is discarded, and the next run reloads.
- Back-to-back divides: run low for at least one cycle between operations. This is required because S clears only on run=0.

Test Plan:
- Unsigned: u=0, x=100, y=7, hold run -> stall high exactly 33 cycles, then quot=14, rem=2, divz=0.
- Signed floored: u=1, x=0xFFFFFFF9 (-7), y=2 -> quot=0xFFFFFFFC (-4), rem=1. Also x=-8, y=2 -> quot=0xFFFFFFFC, rem=0.
- Unsigned large: u=0, x=0xFFFFFFF9, y=2 -> quot=0x7FFFFFFC, rem=1. Also u=1, x=0x80000000, y=1 -> quot=0x80000000, rem=0.
- Divide by zero: u=0, x=0x12345678, y=0 -> divz=1, quot=0xFFFFFFFF, rem=0x12345678, after 33 stall cycles.
- Handshake: run held 5 extra cycles past S=33 -> stall stays 0 and outputs stay constant. Then drop run for 1 cycle, start x=9, y=3 -> a fresh 33-cycle stall, then quot=3, rem=0.
- Reset mid-op: assert rst at S=17 with run high -> next cycle S=0, stall=1. A full 33-cycle divide follows with correct results. Dropping run at S=10 behaves the same way.
